// File: rtl/operand_scoreboard_if.sv
// Decode-side issue bundle for the operand scoreboard: instruction
// operands and flush in, dependency / bypass / stall verdicts out.
interface operand_scoreboard_if #(
    parameter int REG_FILE_LEN = 32,
    parameter int NUM_SRC      = 2,
    parameter int MAX_LAT      = 5,
    parameter int AGE_W        = $clog2(MAX_LAT + 1)
) ();
    localparam int REG_W = $clog2(REG_FILE_LEN);

    logic                       issue_valid;
    logic [NUM_SRC*REG_W-1:0]   issue_src_reg;
    logic [NUM_SRC-1:0]         issue_src_used;
    logic [REG_W-1:0]           issue_dst_reg;
    logic                       issue_wr_en;
    logic [AGE_W-1:0]           issue_rdy_lat;
    logic [AGE_W-1:0]           issue_wb_lat;
    logic                       flush;
    logic [NUM_SRC-1:0]         dep;
    logic [NUM_SRC*AGE_W-1:0]   bypass_sel;
    logic                       stall;
    logic                       issue_accept;

    modport master (
        output issue_valid, issue_src_reg, issue_src_used, issue_dst_reg,
               issue_wr_en, issue_rdy_lat, issue_wb_lat, flush,
        input  dep, bypass_sel, stall, issue_accept
    );

    modport slave (
        input  issue_valid, issue_src_reg, issue_src_used, issue_dst_reg,
               issue_wr_en, issue_rdy_lat, issue_wb_lat, flush,
        output dep, bypass_sel, stall, issue_accept
    );
endinterface

// File: rtl/operand_scoreboard.sv
// Decode-stage operand scoreboard. Tracks every in-flight register write
// with its age, bypass-ready age and writeback age, and answers per source
// operand: is it pending, which stage forwards it, must decode stall.
module operand_scoreboard #(
    parameter int REG_FILE_LEN = 32,
    parameter int NUM_SRC      = 2,
    parameter int MAX_LAT      = 5,
    parameter int AGE_W        = $clog2(MAX_LAT + 1),
    parameter int FLUSH_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    operand_scoreboard_if.slave   bus
);
    localparam int REG_W = $clog2(REG_FILE_LEN);

    // per-register in-flight state; entry 0 is never allocated
    logic             r_busy [REG_FILE_LEN];
    logic [AGE_W-1:0] r_age  [REG_FILE_LEN];
    logic [AGE_W-1:0] r_rdy  [REG_FILE_LEN];
    logic [AGE_W-1:0] r_wb   [REG_FILE_LEN];

    logic [NUM_SRC-1:0]       w_dep;
    logic [NUM_SRC-1:0]       w_src_stall;
    logic [NUM_SRC*AGE_W-1:0] w_byp;
    logic [REG_W-1:0]         w_src [NUM_SRC];
    logic                     w_waw;
    logic                     w_stall;
    logic                     w_accept;
    logic                     w_alloc;

    // per-source lookup: pending write -> dep; bypass once result is ready
    always_comb begin
        w_dep       = '0;
        w_src_stall = '0;
        w_byp       = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            w_src[s] = bus.issue_src_reg[s*REG_W +: REG_W];
            if (bus.issue_src_used[s] && (w_src[s] != '0) && r_busy[w_src[s]]) begin
                w_dep[s] = 1'b1;
                if (r_age[w_src[s]] >= r_rdy[w_src[s]])
                    w_byp[s*AGE_W +: AGE_W] = r_age[w_src[s]];
                else
                    w_src_stall[s] = 1'b1;
            end
        end
    end

    // WAW: the new write must not land at or before the pending one
    always_comb begin
        w_waw = 1'b0;
        if (bus.issue_wr_en && (bus.issue_dst_reg != '0) && r_busy[bus.issue_dst_reg])
            w_waw = (r_wb[bus.issue_dst_reg] - r_age[bus.issue_dst_reg]) >= bus.issue_wb_lat;
    end

    assign w_stall  = bus.issue_valid && ((|w_src_stall) || w_waw);
    assign w_accept = bus.issue_valid && !w_stall && !bus.flush;
    assign w_alloc  = w_accept && bus.issue_wr_en && (bus.issue_dst_reg != '0);

    assign bus.dep          = w_dep;
    assign bus.bypass_sel   = w_byp;
    assign bus.stall        = w_stall;
    assign bus.issue_accept = w_accept;

    // entry update: allocation beats flush-squash, which beats retire/aging
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_FILE_LEN; i++) begin
                r_busy[i] <= 1'b0;
                r_age[i]  <= '0;
                r_rdy[i]  <= '0;
                r_wb[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < REG_FILE_LEN; i++) begin
                if (w_alloc && (bus.issue_dst_reg == REG_W'(i))) begin
                    r_busy[i] <= 1'b1;
                    r_age[i]  <= AGE_W'(1);
                    r_rdy[i]  <= bus.issue_rdy_lat;
                    r_wb[i]   <= bus.issue_wb_lat;
                end else if (r_busy[i]) begin
                    if (bus.flush && (r_age[i] <= AGE_W'(FLUSH_DEPTH)))
                        r_busy[i] <= 1'b0;
                    else if (r_age[i] == r_wb[i])
                        r_busy[i] <= 1'b0;
                    else
                        r_age[i] <= r_age[i] + AGE_W'(1);
                end
            end
        end
    end

    // latencies of a writing instruction must be 1 <= rdy <= wb <= MAX_LAT
    a_lat_range: assert property (@(posedge clk) disable iff (rst)
        (bus.issue_valid && bus.issue_wr_en) |->
            ((bus.issue_rdy_lat != '0) &&
             (bus.issue_wb_lat <= AGE_W'(MAX_LAT)) &&
             (bus.issue_wb_lat >= bus.issue_rdy_lat)));
endmodule
